// File: rtl/bus_grant_encoder.sv
// bus_grant_encoder
//    Registered request-to-select encoder. Turns N drive-request lines into a
//    W-bit bus-mux select code with a valid flag. MODE picks the arbitration
//    rule: 0 = strict one-hot, 1 = fixed priority (lowest index wins),
//    2 = round-robin. Contention is flagged every cycle, and one-hot
//    violations in MODE 0 latch into a sticky debug bit.
//
// Ports
//    clock_i      rising-edge clock
//    clear_i      synchronous active-low reset; overrides hold_i and err_clr_i
//    req_i        request lines, bit i = source i wants the bus
//    hold_i       1 = freeze code/valid/conflict/pointer and ignore req_i
//    err_clr_i    clears multi_err_o (a simultaneous new violation wins)
//    code_o       registered select code of the granted source
//    valid_o      registered, 1 = code_o is a fresh grant this cycle
//    conflict_o   registered, 1 = two or more requests in the sampled cycle
//    multi_err_o  sticky one-hot violation flag (MODE 0 only)
module bus_grant_encoder #(
   parameter int N    = 32,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         clock_i,
   input  logic         clear_i,
   input  logic [N-1:0] req_i,
   input  logic         hold_i,
   input  logic         err_clr_i,
   output logic [W-1:0] code_o,
   output logic         valid_o,
   output logic         conflict_o,
   output logic         multi_err_o
);

   logic [W-1:0] code_q,      code_d;
   logic         valid_q,     valid_d;
   logic         conflict_q,  conflict_d;
   logic         multi_err_q, multi_err_d;
   logic [W-1:0] ptr_q,       ptr_d;

   logic         any_req;
   logic         multi_req;
   logic [W-1:0] low_idx;
   logic [W-1:0] rr_idx;
   logic         rr_found;
   int           rr_j;
   logic [W-1:0] rr_jw;

   assign any_req   = |req_i;
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_req = |(req_i & (req_i - N'(1)));

   always_comb begin
      low_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) low_idx = W'(i);
      end
   end

   // Upward search from the pointer. The wrap is an explicit subtract of N so
   // a non-power-of-2 N never produces an index past N-1.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      rr_j     = 0;
      rr_jw    = '0;
      for (int off = 0; off < N; off++) begin
         rr_j = int'(ptr_q) + off;
         if (rr_j >= N) rr_j = rr_j - N;
         rr_jw = W'(rr_j);
         if (!rr_found && req_i[rr_jw]) begin
            rr_found = 1'b1;
            rr_idx   = rr_jw;
         end
      end
   end

   always_comb begin
      code_d      = code_q;
      valid_d     = 1'b0;
      conflict_d  = multi_req;
      ptr_d       = ptr_q;
      multi_err_d = multi_err_q;

      if (MODE == 1) begin
         if (any_req) begin
            code_d  = low_idx;
            valid_d = 1'b1;
         end
      end else if (MODE == 2) begin
         if (rr_found) begin
            code_d  = rr_idx;
            valid_d = 1'b1;
            ptr_d   = (rr_idx == W'(N - 1)) ? '0 : rr_idx + W'(1);
         end
      end else begin
         if (any_req && !multi_req) begin
            code_d  = low_idx;
            valid_d = 1'b1;
         end
      end

      // Set has priority over clear; held cycles never count as violations.
      if (MODE != 1 && MODE != 2 && !hold_i && multi_req) begin
         multi_err_d = 1'b1;
      end else if (err_clr_i) begin
         multi_err_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!clear_i) begin
         code_q      <= '0;
         valid_q     <= 1'b0;
         conflict_q  <= 1'b0;
         ptr_q       <= '0;
         multi_err_q <= 1'b0;
      end else begin
         if (!hold_i) begin
            code_q     <= code_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            ptr_q      <= ptr_d;
         end
         multi_err_q <= multi_err_d;
      end
   end

   assign code_o      = code_q;
   assign valid_o     = valid_q;
   assign conflict_o  = conflict_q;
   assign multi_err_o = multi_err_q;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Bench for bus_grant_encoder: four instances (one-hot, priority and
// round-robin at N=32, round-robin at N=5) share one stimulus stream.
module tb_bus_grant_encoder;

   logic        clk;
   logic        clear;
   logic        hold;
   logic        err_clr;
   logic [31:0] req;

   logic [4:0] code0, code1, code2;
   logic [2:0] code5;
   logic       valid0, valid1, valid2, valid5;
   logic       conf0, conf1, conf2, conf5;
   logic       merr0, merr1, merr2, merr5;

   int n_checks = 0;
   int n_errors = 0;

   bus_grant_encoder #(.N(32), .MODE(0)) u_m0 (
      .clock_i(clk), .clear_i(clear), .req_i(req), .hold_i(hold), .err_clr_i(err_clr),
      .code_o(code0), .valid_o(valid0), .conflict_o(conf0), .multi_err_o(merr0));
   bus_grant_encoder #(.N(32), .MODE(1)) u_m1 (
      .clock_i(clk), .clear_i(clear), .req_i(req), .hold_i(hold), .err_clr_i(err_clr),
      .code_o(code1), .valid_o(valid1), .conflict_o(conf1), .multi_err_o(merr1));
   bus_grant_encoder #(.N(32), .MODE(2)) u_m2 (
      .clock_i(clk), .clear_i(clear), .req_i(req), .hold_i(hold), .err_clr_i(err_clr),
      .code_o(code2), .valid_o(valid2), .conflict_o(conf2), .multi_err_o(merr2));
   bus_grant_encoder #(.N(5), .MODE(2)) u_n5 (
      .clock_i(clk), .clear_i(clear), .req_i(req[4:0]), .hold_i(hold), .err_clr_i(err_clr),
      .code_o(code5), .valid_o(valid5), .conflict_o(conf5), .multi_err_o(merr5));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic step(input logic [31:0] r, input logic h, input logic c, input logic e);
      req     = r;
      hold    = h;
      clear   = c;
      err_clr = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(32'h0, 1'b0, 1'b0, 1'b0);
      step(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if ({valid0, conf0, merr0, code0} !== 8'h00) begin
         n_errors++;
         $display("FAIL reset_m0: got %h expected 00", {valid0, conf0, merr0, code0});
      end
      n_checks++;
      if ({valid2, conf2, merr2, code2, valid5, conf5, merr5, code5} !== 14'h0) begin
         n_errors++;
         $display("FAIL reset_rr: got %h expected 0",
                  {valid2, conf2, merr2, code2, valid5, conf5, merr5, code5});
      end
   endtask

   task automatic test_walk();
      logic [7:0] exp;
      for (int i = 0; i < 32; i++) begin
         step(32'h1 << i, 1'b0, 1'b1, 1'b0);
         exp = {3'b100, 5'(i)};
         n_checks++;
         if ({valid0, conf0, merr0, code0} !== exp) begin
            n_errors++;
            $display("FAIL walk bit%0d: got {v,c,e,code}=%h expected %h", i,
                     {valid0, conf0, merr0, code0}, exp);
         end
      end
   endtask

   task automatic test_onehot_violation();
      logic [31:0] r_tab [6] = '{32'h20, 32'h21, 32'h8, 32'h3, 32'h0, 32'h0};
      logic        e_tab [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0]  x_tab [6] = '{{3'b100, 5'd5}, {3'b011, 5'd5}, {3'b100, 5'd3},
                                 {3'b011, 5'd3}, {3'b001, 5'd3}, {3'b000, 5'd3}};
      for (int i = 0; i < 6; i++) begin
         step(r_tab[i], 1'b0, 1'b1, e_tab[i]);
         n_checks++;
         if ({valid0, conf0, merr0, code0} !== x_tab[i]) begin
            n_errors++;
            $display("FAIL onehot step%0d: got {v,c,e,code}=%h expected %h", i,
                     {valid0, conf0, merr0, code0}, x_tab[i]);
         end
      end
      n_checks++;
      if ({merr1, merr2, merr5} !== 3'b000) begin
         n_errors++;
         $display("FAIL merr_other_modes: got %b expected 000", {merr1, merr2, merr5});
      end
   endtask

   task automatic test_priority();
      step(32'h8000_0110, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({valid1, conf1, merr1, code1} !== {3'b110, 5'd4}) begin
         n_errors++;
         $display("FAIL prio_grant: got %h expected %h", {valid1, conf1, merr1, code1},
                  {3'b110, 5'd4});
      end
      step(32'h0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({valid1, conf1, merr1, code1} !== {3'b000, 5'd4}) begin
         n_errors++;
         $display("FAIL prio_idle: got %h expected %h", {valid1, conf1, merr1, code1},
                  {3'b000, 5'd4});
      end
   endtask

   task automatic test_round_robin();
      int g_tab [5] = '{0, 1, 31, 0, 1};
      step(32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(32'h8000_0003, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({valid2, conf2, merr2, code2} !== {3'b110, 5'(g_tab[i])}) begin
            n_errors++;
            $display("FAIL rr_grant%0d: got code=%0d v=%b c=%b expected code=%0d v=1 c=1",
                     i, code2, valid2, conf2, g_tab[i]);
         end
      end
   endtask

   task automatic test_hold_reset();
      // {hold, clear, err_clr} per cycle, req fixed at 0x3
      logic [2:0] ctl_tab [10] = '{3'b000, 3'b110, 3'b110, 3'b110, 3'b010,
                                   3'b111, 3'b110, 3'b110, 3'b010, 3'b010};
      logic [7:0] x_tab [10];
      x_tab[0] = 8'h00;               x_tab[1] = 8'h00;
      x_tab[2] = 8'h00;               x_tab[3] = 8'h00;
      x_tab[4] = {3'b110, 5'd0};      x_tab[5] = {3'b110, 5'd0};
      x_tab[6] = {3'b110, 5'd0};      x_tab[7] = {3'b110, 5'd0};
      x_tab[8] = {3'b110, 5'd1};      x_tab[9] = {3'b110, 5'd0};
      for (int i = 0; i < 10; i++) begin
         step(32'h3, ctl_tab[i][2], ctl_tab[i][1], ctl_tab[i][0]);
         n_checks++;
         if ({valid2, conf2, merr2, code2} !== x_tab[i]) begin
            n_errors++;
            $display("FAIL hold step%0d: got %h expected %h", i,
                     {valid2, conf2, merr2, code2}, x_tab[i]);
         end
         if (i == 3 || i == 5) begin
            // held violations are ignored; err_clr still acts while held
            n_checks++;
            if (merr0 !== 1'b0) begin
               n_errors++;
               $display("FAIL hold_merr step%0d: got %b expected 0", i, merr0);
            end
         end
      end
      // ptr is now 1: a reset must restart the search at 0
      step(32'h3, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({valid2, conf2, merr2, code2} !== 8'h00) begin
         n_errors++;
         $display("FAIL midrun_reset: got %h expected 00", {valid2, conf2, merr2, code2});
      end
      step(32'h3, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({valid2, code2} !== {1'b1, 5'd0}) begin
         n_errors++;
         $display("FAIL post_reset_grant: got v=%b code=%0d expected v=1 code=0", valid2, code2);
      end
   endtask

   task automatic test_non_pow2();
      int g_tab [3] = '{4, 0, 4};
      step(32'h0, 1'b0, 1'b0, 1'b0);
      step(32'h08, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if ({valid5, conf5, code5} !== {2'b10, 3'd3}) begin
         n_errors++;
         $display("FAIL n5_setup: got v=%b c=%b code=%0d expected v=1 c=0 code=3",
                  valid5, conf5, code5);
      end
      for (int i = 0; i < 3; i++) begin
         step(32'h11, 1'b0, 1'b1, 1'b0);
         n_checks++;
         if ({valid5, conf5, code5} !== {2'b11, 3'(g_tab[i])}) begin
            n_errors++;
            $display("FAIL n5_grant%0d: got v=%b c=%b code=%0d expected v=1 c=1 code=%0d",
                     i, valid5, conf5, code5, g_tab[i]);
         end
      end
   endtask

   // Reference model: per-instance state tracked as plain integers; grants
   // come from counting bits and a modulo-N search, independent of the RTL.
   task automatic test_random();
      int nn [4] = '{32, 32, 32, 5};
      int md [4] = '{0, 1, 2, 2};
      int mcode [4], mval [4], mconf [4], merr [4], mptr [4];
      int acode [4], aval [4], aconf [4], aerr [4];
      logic [31:0] r, rm;
      logic h, c, e;
      int cnt, g, idx;
      step(32'h0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         mcode[k] = 0; mval[k] = 0; mconf[k] = 0; merr[k] = 0; mptr[k] = 0;
      end
      for (int t = 0; t < 400; t++) begin
         case ($urandom_range(0, 3))
            0: r = 32'h0;
            1: r = 32'h1 << $urandom_range(0, 31);
            2: r = $urandom;
            default: r = (32'h1 << $urandom_range(0, 4)) | (32'h1 << $urandom_range(0, 4));
         endcase
         h = ($urandom_range(0, 9) == 0);
         e = ($urandom_range(0, 6) == 0);
         c = ($urandom_range(0, 39) != 0);
         step(r, h, c, e);
         for (int k = 0; k < 4; k++) begin
            if (!c) begin
               mcode[k] = 0; mval[k] = 0; mconf[k] = 0; merr[k] = 0; mptr[k] = 0;
            end else begin
               rm  = (nn[k] == 32) ? r : (r & ((32'h1 << nn[k]) - 1));
               cnt = $countones(rm);
               if (!h) begin
                  mconf[k] = (cnt >= 2) ? 1 : 0;
                  g = -1;
                  if (md[k] == 2) begin
                     for (int o = 0; o < nn[k]; o++) begin
                        idx = (mptr[k] + o) % nn[k];
                        if (g < 0 && rm[idx]) g = idx;
                     end
                  end else begin
                     for (int b = nn[k] - 1; b >= 0; b--) if (rm[b]) g = b;
                  end
                  if (md[k] == 0 && cnt != 1) g = -1;
                  if (g >= 0) begin
                     mcode[k] = g;
                     mval[k]  = 1;
                     if (md[k] == 2) mptr[k] = (g + 1) % nn[k];
                  end else begin
                     mval[k] = 0;
                  end
               end
               if (md[k] == 0 && !h && cnt >= 2) merr[k] = 1;
               else if (e) merr[k] = 0;
            end
         end
         acode[0] = int'(code0); aval[0] = int'(valid0); aconf[0] = int'(conf0); aerr[0] = int'(merr0);
         acode[1] = int'(code1); aval[1] = int'(valid1); aconf[1] = int'(conf1); aerr[1] = int'(merr1);
         acode[2] = int'(code2); aval[2] = int'(valid2); aconf[2] = int'(conf2); aerr[2] = int'(merr2);
         acode[3] = int'(code5); aval[3] = int'(valid5); aconf[3] = int'(conf5); aerr[3] = int'(merr5);
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({acode[k], aval[k], aconf[k], aerr[k]} !== {mcode[k], mval[k], mconf[k], merr[k]}) begin
               n_errors++;
               $display("FAIL rand inst%0d cycle%0d: got code=%0d v=%0d c=%0d e=%0d expected code=%0d v=%0d c=%0d e=%0d",
                        k, t, acode[k], aval[k], aconf[k], aerr[k],
                        mcode[k], mval[k], mconf[k], merr[k]);
            end
         end
      end
   endtask

   initial begin
      req     = 32'h0;
      hold    = 1'b0;
      clear   = 1'b0;
      err_clr = 1'b0;
      test_reset();
      test_walk();
      test_onehot_violation();
      test_priority();
      test_round_robin();
      test_hold_reset();
      test_non_pow2();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_grant_encoder.md
Name: bus_grant_encoder

Overview:
- Parametrised, registered successor to the bus-select encoder.
- Converts N drive-request lines (register/unit "out" enables) into a W-bit bus-mux select code plus a valid flag.
- Three arbitration modes: strict one-hot, fixed priority and round-robin.
- Flags contention and records illegal one-hot violations in a sticky error bit for debug.

Parameters:
- N, 32: number of request lines (2..64).
- W, $clog2(N): select code width (5 for N=32).
- MODE, 0: 0 = strict one-hot; 1 = fixed priority (lowest index wins); 2 = round-robin.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  synchronous active-low reset, sampled on the rising edge of clock.
- req  in  N  request lines; bit i = source i wants the bus.
- hold  in  1  1 = freeze all state (code, valid, conflict, pointer); err_clr still acts.
- err_clr  in  1  clears multi_err.
- code  out  W  registered select code of the granted source.
- valid  out  1  registered; 1 = code is a fresh grant this cycle.
- conflict  out  1  registered; 1 = more than one req bit was set in the sampled cycle.
- multi_err  out  1  sticky; set on a one-hot violation in MODE 0.

Behaviour:
- Reset (clear=0 at posedge): code=0, valid=0, conflict=0, multi_err=0, rr pointer ptr=0. Reset overrides hold and err_clr.
- Latency: req sampled at edge k drives code/valid/conflict after edge k. Outputs come directly from flops, with no combinational path from req.
- conflict (all modes): set to 1 iff popcount(req) >= 2, else 0.
- MODE 0, exactly one bit i set: code<=i, valid<=1.
- MODE 0, req==0: valid<=0, code holds its previous value.
- MODE 0, two or more bits set: valid<=0, code holds, multi_err<=1.
- MODE 1: if req!=0, code<=index of the lowest set bit and valid<=1. Otherwise valid<=0 and code holds. multi_err is never set.
- MODE 2: search upward from ptr, wrapping N-1 -> 0. The first set bit g wins: code<=g, valid<=1, ptr<=(g==N-1)?0:g+1.
- MODE 2, req==0: valid<=0, code and ptr hold. multi_err is never set.
- Non-power-of-2 N: ptr and code never exceed N-1. Wrap is explicit, not modulo 2^W.
- hold=1 (clear=1): code, valid, conflict and ptr keep their values. Requests in that cycle are ignored and are not counted as errors.
- err_clr=1: multi_err<=0 on the next edge.
- err_clr=1 with a simultaneous new violation: set wins, so multi_err stays 1.
- Reset mid-operation: the pointer returns to 0, and the next grant is computed from a fresh search starting at 0.
- Only the low-order N bits exist. There is no X output in any mode; the old encoder's "x" default is replaced by valid=0.

Test Plan:
- Reset/walk (N=32, MODE 0): hold clear=0 for 2 cycles, so all outputs are 0. Then walk a single 1 across bits 0..31, one per cycle. code must track 0..31 one cycle later with valid=1, conflict=0 and multi_err=0.
- One-hot violation (MODE 0): after a grant of code=5, drive req=0x0000_0021 to get valid=0, code=5, conflict=1, multi_err=1. Then drive req=0x8 with err_clr=1 to get code=3, valid=1, multi_err=0. Repeat with err_clr=1 plus req=0x3 in the same cycle; multi_err must stay 1.
- Priority (MODE 1): req=0x8000_0110 -> code=4, valid=1, conflict=1, multi_err=0. Then req=0 -> valid=0, code=4.
- Round-robin fairness and wrap (MODE 2): hold req=0x8000_0003 for 4 cycles. Grants must be 0, 1, 31, 0, and ptr must wrap 31 -> 0.
- hold/reset mid-run (MODE 2): with req=0x3, hold=1 for 3 cycles must keep code and valid unchanged. Then assert clear=0 for 1 cycle, then release. The first grant must be code=0.
- Non-power-of-2 (N=5, W=3, MODE 2): hold req=5'b10001 for 3 cycles. Grants must be 4, 0, 4 (assuming ptr=4 at start), and code must never reach 5..7.
